// File: rtl/qam16_rail_slicer_mer_pkg.sv
// Shared types and constants for the 16-QAM per-rail slicer / MER engine.
package qam16_rail_slicer_mer_pkg;

  localparam int unsigned DATA_W = 18;  // signed 1s17 sample width
  localparam int unsigned ABS_W  = 17;  // |x| width (unsigned)
  localparam int unsigned SQ_W   = 35;  // error^2 width (unsigned)
  localparam int unsigned WIDE_W = 20;  // slicer arithmetic width

  // Per-rail Gray decision codes
  typedef enum logic [1:0] {
    LVL_M3 = 2'b00,
    LVL_M1 = 2'b01,
    LVL_P1 = 2'b11,
    LVL_P3 = 2'b10
  } level_e;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } state_e;

  // Clamp a 20-bit signed slicer result into the 1s17 output range
  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [WIDE_W-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > 20'sd131071)
      r = 18'sh1FFFF;
    else if (v < -20'sd131072)
      r = 18'sh20000;
    else
      r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/qam16_rail_slicer_mer_acc.sv
// Window accumulator: load a fresh term, add a term, or dump (clear) after the
// window total has been consumed. The window counter lives in the parent so
// that the |x| and error^2 instances stay in lock-step.
module mer_window_acc #(
  parameter int unsigned WIDTH    = 17,
  parameter int unsigned ACC_LOG2 = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         add,
  input  logic                         dump,
  input  logic [WIDTH-1:0]             term,
  output logic [WIDTH+ACC_LOG2-1:0]    total
);

  localparam int unsigned ACC_W = WIDTH + ACC_LOG2;

  logic [ACC_W-1:0] acc_q;

  // Running sum including the current symbol's term
  assign total = acc_q + ACC_W'(term);

  // Accumulator register: load wins over dump wins over add
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc_q <= '0;
    else if (load)
      acc_q <= ACC_W'(term);
    else if (dump)
      acc_q <= '0;
    else if (add)
      acc_q <= total;
  end

endmodule

// File: rtl/qam16_rail_slicer_mer.sv
// Per-rail 16-QAM decision slicer with adaptive reference level and
// windowed MER statistics (mean |x| -> reference, mean error^2 -> power).
module qam16_rail_slicer_mer
  import qam16_rail_slicer_mer_pkg::*;
#(
  parameter int unsigned ACC_LOG2 = 12,
  parameter int          REF_INIT = 32768
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     cycle_start,
  input  logic signed [DATA_W-1:0] dec_var,
  output logic [1:0]               sym_out,
  output logic signed [DATA_W-1:0] error,
  output logic signed [DATA_W-1:0] ref_level,
  output logic [SQ_W-1:0]          error_power,
  output logic                     acc_valid,
  output logic                     locked
);

  localparam logic signed [DATA_W-1:0] REF_RST = DATA_W'(REF_INIT);
  localparam int unsigned ABS_ACC_W = ABS_W + ACC_LOG2;
  localparam int unsigned SQ_ACC_W  = SQ_W + ACC_LOG2;

  state_e state_q, state_d;

  logic [ACC_LOG2-1:0] cnt_q;
  logic                last_sym;
  logic                win_load, win_add, win_dump;

  logic signed [WIDE_W-1:0] x_w, b_w, two_b, three_b, lvl_w, err_w;
  level_e                   lvl;
  logic signed [DATA_W-1:0] err_c;
  logic [ABS_W-1:0]         abs_c;
  logic signed [2*DATA_W-1:0] sq_full;
  logic [SQ_W-1:0]          sq_c;

  logic [ABS_ACC_W-1:0] abs_total;
  logic [SQ_ACC_W-1:0]  sq_total;

  assign x_w     = WIDE_W'(dec_var);
  assign b_w     = WIDE_W'(ref_level);
  assign two_b   = b_w <<< 1;
  assign three_b = two_b + b_w;

  // Decision against thresholds -2b/0/+2b; x=0 maps to +b, x=2b to +3b
  always_comb begin
    lvl   = LVL_P1;
    lvl_w = b_w;
    if (x_w < -two_b) begin
      lvl   = LVL_M3;
      lvl_w = -three_b;
    end else if (x_w < 20'sd0) begin
      lvl   = LVL_M1;
      lvl_w = -b_w;
    end else if (x_w < two_b) begin
      lvl   = LVL_P1;
      lvl_w = b_w;
    end else begin
      lvl   = LVL_P3;
      lvl_w = three_b;
    end
  end

  assign err_w = x_w - lvl_w;
  assign err_c = sat_data(err_w);

  // |x| with the most negative input clamped to the positive maximum
  always_comb begin
    abs_c = dec_var[ABS_W-1:0];
    if (dec_var[DATA_W-1]) begin
      if (dec_var == 18'sh20000)
        abs_c = '1;
      else
        abs_c = ABS_W'(-dec_var);
    end
  end

  assign sq_full  = err_c * err_c;
  assign sq_c     = sq_full[SQ_W-1:0];
  assign last_sym = &cnt_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= WAIT_SYNC;
    else
      state_q <= state_d;
  end

  // Next state and window controls; a marker always restarts the window
  always_comb begin
    state_d  = state_q;
    win_load = 1'b0;
    win_add  = 1'b0;
    win_dump = 1'b0;
    unique case (state_q)
      WAIT_SYNC: begin
        if (clk_en && cycle_start) begin
          state_d  = ACCUM;
          win_load = 1'b1;
        end
      end
      ACCUM: begin
        if (clk_en) begin
          if (cycle_start)
            win_load = 1'b1;
          else if (last_sym)
            win_dump = 1'b1;
          else
            win_add = 1'b1;
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  // Shared window counter: number of terms already in the accumulators
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (win_load)
      cnt_q <= ACC_LOG2'(1);
    else if (win_dump)
      cnt_q <= '0;
    else if (win_add)
      cnt_q <= cnt_q + 1'b1;
  end

  mer_window_acc #(
    .WIDTH    (ABS_W),
    .ACC_LOG2 (ACC_LOG2)
  ) u_abs_acc (
    .clk   (clk),
    .reset (reset),
    .load  (win_load),
    .add   (win_add),
    .dump  (win_dump),
    .term  (abs_c),
    .total (abs_total)
  );

  mer_window_acc #(
    .WIDTH    (SQ_W),
    .ACC_LOG2 (ACC_LOG2)
  ) u_sq_acc (
    .clk   (clk),
    .reset (reset),
    .load  (win_load),
    .add   (win_add),
    .dump  (win_dump),
    .term  (sq_c),
    .total (sq_total)
  );

  // Registered decision and error, updated once per symbol
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_out <= LVL_P1;
      error   <= '0;
    end else if (clk_en) begin
      sym_out <= lvl;
      error   <= err_c;
    end
  end

  // Window results; acc_valid is a single-clk pulse independent of clk_en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_level   <= REF_RST;
      error_power <= '0;
      acc_valid   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      acc_valid <= win_dump;
      if (win_dump) begin
        ref_level   <= DATA_W'(abs_total >> (ACC_LOG2 + 1));
        error_power <= SQ_W'(sq_total >> ACC_LOG2);
        locked      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qam16_rail_slicer_mer.sv
// Self-checking bench for qam16_rail_slicer_mer (ACC_LOG2=4, REF_INIT=32768).
module tb_qam16_rail_slicer_mer;

  localparam int WIN = 16;

  logic clk = 1'b0;
  logic reset, clk_en, cycle_start;
  logic signed [17:0] dec_var;
  logic [1:0]         sym_out;
  logic signed [17:0] error;
  logic signed [17:0] ref_level;
  logic [34:0]        error_power;
  logic               acc_valid, locked;

  always #5 clk = ~clk;

  qam16_rail_slicer_mer #(
    .ACC_LOG2 (4),
    .REF_INIT (32768)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .cycle_start (cycle_start),
    .dec_var     (dec_var),
    .sym_out     (sym_out),
    .error       (error),
    .ref_level   (ref_level),
    .error_power (error_power),
    .acc_valid   (acc_valid),
    .locked      (locked)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int valid_seen = 0;

  // Reference model state
  longint m_b, m_pow, m_err;
  logic [1:0] m_sym;
  bit m_valid, m_locked, m_synced;
  longint abs_q[$];
  longint sq_q[$];

  longint pat1 [4] = '{32768, -32768, 98304, -98304};
  longint pat2 [4] = '{33768, -31768, 99304, -97304};
  longint thr_x   [5] = '{0, 65535, 65536, -65536, -131072};
  longint thr_sym [5] = '{3, 3, 2, 1, 0};
  longint thr_err [5] = '{-32768, 32767, -32768, -32768, -32768};

  task automatic check(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_sym"},    longint'(sym_out),     longint'(m_sym));
    check({tag, "_err"},    longint'(error),       m_err);
    check({tag, "_ref"},    longint'(ref_level),   m_b);
    check({tag, "_pow"},    longint'(error_power), m_pow);
    check({tag, "_valid"},  longint'(acc_valid),   longint'(m_valid));
    check({tag, "_locked"}, longint'(locked),      longint'(m_locked));
  endtask

  function automatic void model_reset();
    m_b = 32768; m_pow = 0; m_err = 0; m_sym = 2'b11;
    m_valid = 0; m_locked = 0; m_synced = 0;
    abs_q.delete(); sq_q.delete();
  endfunction

  // Model of one symbol: nearest of {-3b,-b,+b,+3b} with ties upward,
  // window means taken over the last 16 terms since a marker.
  function automatic void model_symbol(input longint x, input bit cs);
    longint lvl, e, a, sa, ss;
    if (x < -2 * m_b)      begin m_sym = 2'b00; lvl = -3 * m_b; end
    else if (x < 0)        begin m_sym = 2'b01; lvl = -m_b;     end
    else if (x < 2 * m_b)  begin m_sym = 2'b11; lvl = m_b;      end
    else                   begin m_sym = 2'b10; lvl = 3 * m_b;  end
    e = x - lvl;
    if (e > 131071)  e = 131071;
    if (e < -131072) e = -131072;
    m_err = e;
    a = (x < 0) ? -x : x;
    if (a > 131071) a = 131071;
    m_valid = 0;
    if (cs) begin
      abs_q.delete(); sq_q.delete();
      m_synced = 1;
    end
    if (m_synced) begin
      abs_q.push_back(a);
      sq_q.push_back(e * e);
      if (abs_q.size() == WIN) begin
        sa = 0; ss = 0;
        foreach (abs_q[i]) sa += abs_q[i];
        foreach (sq_q[i])  ss += sq_q[i];
        m_b = sa / (2 * WIN);
        m_pow = ss / WIN;
        m_valid = 1;
        m_locked = 1;
        abs_q.delete(); sq_q.delete();
      end
    end
  endfunction

  task automatic sym(input longint x, input bit cs);
    @(negedge clk);
    dec_var = x[17:0];
    cycle_start = cs;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    cycle_start = 1'b0;
    model_symbol(x, cs);
    if (acc_valid) valid_seen++;
    check_outputs("sym");
  endtask

  task automatic idle(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (toggle) begin
        dec_var = 18'($urandom);
        cycle_start = 1'($urandom);
      end
      @(posedge clk);
      #1;
      m_valid = 0;
      if (acc_valid) valid_seen++;
      check_outputs("idle");
    end
    cycle_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic longint near_level();
    longint base;
    base = 32768 * ((($urandom % 4) * 2) - 3);
    return base + longint'($urandom_range(16000)) - 8000;
  endfunction

  initial begin
    reset = 1'b0; clk_en = 1'b0; cycle_start = 1'b0; dec_var = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Test 1: clean constellation points
    valid_seen = 0;
    for (int i = 0; i < WIN; i++) sym(pat1[i % 4], i == 0);
    check("t1_valid_count", valid_seen, 1);
    check("t1_ref", longint'(ref_level), 32768);
    check("t1_pow", longint'(error_power), 0);
    check("t1_locked", longint'(locked), 1);
    idle(1, 0);

    // Test 2: constant +1000 offset
    for (int i = 0; i < WIN; i++) begin
      sym(pat2[i % 4], 0);
      check("t2_err", longint'(error), 1000);
    end
    check("t2_ref", longint'(ref_level), 32768);
    check("t2_pow", longint'(error_power), 1000000);

    // Test 3: threshold boundaries at b=32768
    for (int i = 0; i < 5; i++) begin
      sym(thr_x[i], 0);
      check("t3_sym", longint'(sym_out), thr_sym[i]);
      check("t3_err", longint'(error), thr_err[i]);
    end

    // Test 4: markers at symbols 0, 7 and 15 restart the window
    valid_seen = 0;
    for (int i = 0; i < WIN; i++) sym(near_level(), (i == 0) || (i == 7) || (i == 15));
    for (int i = 0; i < WIN - 2; i++) sym(near_level(), 0);
    check("t4_no_valid_early", valid_seen, 0);
    sym(near_level(), 0);
    check("t4_valid_after_16", valid_seen, 1);

    // Test 5: asynchronous reset between clock edges, mid-window
    for (int i = 0; i < 5; i++) sym(near_level(), i == 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs("t5_async");
    @(negedge clk);
    reset = 1'b1;
    valid_seen = 0;
    for (int i = 0; i < 20; i++) sym(near_level(), 0);
    check("t5_no_valid_unsynced", valid_seen, 0);
    for (int i = 0; i < WIN; i++) sym(near_level(), i == 0);
    check("t5_valid_after_sync", valid_seen, 1);

    // Test 6: clk_en stalled mid-window with inputs toggling
    do_reset();
    valid_seen = 0;
    for (int i = 0; i < 8; i++) sym(pat1[i % 4], i == 0);
    idle(10, 1);
    for (int i = 8; i < WIN; i++) sym(pat1[i % 4], 0);
    check("t6_valid_count", valid_seen, 1);
    check("t6_ref", longint'(ref_level), 32768);
    check("t6_pow", longint'(error_power), 0);

    // Random: full-range samples, sparse markers, random gaps
    for (int i = 0; i < 400; i++) begin
      longint x;
      if ($urandom % 4 == 0)
        x = longint'($signed(18'($urandom)));
      else
        x = near_level();
      sym(x, ($urandom % 50) == 0);
      idle(int'($urandom % 3), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
